ph_sample_receiver: RTL and testbench

- Serial front end that delivers 4-bit blood pH codes to the `bloodPHAnalyzer` input.
- Deframes the sensor's asynchronous serial line, checks framing and (optionally) parity, and holds the last good sample on `bloodPH`.
- Each accepted sample is announced with a one-cycle `phValid` strobe.
- Sits between the sensor pad and the analyzer; the analyzer consumes `bloodPH` combinationally.

---
 rtl/ph_rx_pkg.sv | 21 ++
 rtl/ph_rx_bit_sync.sv | 26 ++
 rtl/ph_sample_receiver.sv | 161 ++++++++++++++++
 tb/tb_ph_sample_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ph_rx_pkg.sv
// ph_rx_pkg: shared types and constants for the pH sample receiver.
//   rx_state_t        receiver FSM states
//   PH_W              width of one pH code
//   FRAME_BITS_PAR    serial frame length with the parity bit present
//   FRAME_BITS_NOPAR  serial frame length without the parity bit
package ph_rx_pkg;

  localparam int PH_W             = 4;
  localparam int FRAME_BITS_PAR   = 7;
  localparam int FRAME_BITS_NOPAR = 6;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/ph_rx_bit_sync.sv
// ph_bit_sync: two-flop synchroniser for the asynchronous sensor line.
// Both flops reset to 1 so a reset never looks like a start bit.
//   clk  in   system clock
//   rst  in   synchronous active-high reset
//   d    in   raw asynchronous input
//   q    out  synchronised copy of d (2-cycle latency)
module ph_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ph_sample_receiver.sv
// ph_sample_receiver: deframes the pH sensor serial line and holds the last
// good 4-bit sample for the analyzer.
// Frame: start(0), D3..D0 MSB first, [even parity], stop(1).
// Build option: define PH_PARITY_EN to include and check the parity bit;
// without it the frame is 6 bits and only the stop bit is checked.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   sdi       in   raw serial line, idle high, asynchronous
//   bloodPH   out  last accepted pH code
//   phValid   out  one-cycle pulse when bloodPH was just updated
//   frameErr  out  one-cycle pulse when a frame was rejected
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | timing to mid start bit to reject glitches
// DATA      | sampling D3..D0 once per bit period
// PARITY    | sampling the parity bit (PH_PARITY_EN only)
// STOP      | sampling the stop bit, deciding accept/reject
// WAIT_IDLE | after a missing stop bit, waiting for the line to go high
module ph_sample_receiver
  import ph_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sdi,
  output logic [PH_W-1:0] bloodPH,
  output logic            phValid,
  output logic            frameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

  logic            sdi_s;
  rx_state_t       state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [1:0]      idx, idx_next;
  logic [PH_W-1:0] shift, shift_next;
  logic [PH_W-1:0] ph_next;
  logic            valid_next, err_next;
  logic            parity_ok;

  ph_bit_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sdi),
    .q   (sdi_s)
  );

`ifdef PH_PARITY_EN
  logic par_bit, par_next;
  // Even parity over data plus parity bit.
  assign parity_ok = ~^{shift, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      bloodPH  <= '0;
      phValid  <= 1'b0;
      frameErr <= 1'b0;
`ifdef PH_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      shift    <= shift_next;
      bloodPH  <= ph_next;
      phValid  <= valid_next;
      frameErr <= err_next;
`ifdef PH_PARITY_EN
      par_bit  <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    shift_next = shift;
    ph_next    = bloodPH;
    valid_next = 1'b0;
    err_next   = 1'b0;
`ifdef PH_PARITY_EN
    par_next   = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!sdi_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_TC) begin
          cnt_next   = '0;
          idx_next   = '0;
          // A high level at mid start bit is a glitch, not an error.
          state_next = sdi_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_TC) begin
          cnt_next   = '0;
          shift_next = {shift[PH_W-2:0], sdi_s};
          idx_next   = idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef PH_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef PH_PARITY_EN
      PARITY: begin
        if (cnt == FULL_TC) begin
          cnt_next   = '0;
          par_next   = sdi_s;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_TC) begin
          cnt_next = '0;
          if (!sdi_s) begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end else if (parity_ok) begin
            ph_next    = shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (sdi_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ph_sample_receiver.sv
module tb_ph_sample_receiver;

  localparam int N = 4;
`ifdef PH_PARITY_EN
  localparam int FB = 7;
`else
  localparam int FB = 6;
`endif
  // Posedges from driving the raw falling edge to the status pulse being visible:
  // 2 sync cycles + stop sample offset + 1 registered cycle.
  localparam int LAT = 2 + N / 2 + (FB - 1) * N + 1;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  logic       clk, rst, sdi;
  logic [3:0] bloodPH;
  logic       phValid, frameErr;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  ev_t exp_v[$], got_v[$];
  int  exp_e[$], got_e[$];
  logic [3:0] model_ph;

  ph_sample_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .sdi      (sdi),
    .bloodPH  (bloodPH),
    .phValid  (phValid),
    .frameErr (frameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (phValid || frameErr) check("exclusive", {31'b0, phValid & frameErr}, 32'd0);
      if (phValid) got_v.push_back('{cyc: cyc, val: bloodPH});
      if (frameErr) got_e.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Hold a line level for n cycles; at_cyc is the posedge count when it was applied.
  task automatic drive_level(input logic lvl, input int n, output int at_cyc);
    @(posedge clk);
    #1 sdi = lvl;
    at_cyc = cyc;
    repeat (n - 1) @(posedge clk);
  endtask

  // Reference outcome of one frame from the line-level rules.
  function automatic logic frame_ok(input logic [3:0] d, input logic p, input logic stp);
`ifdef PH_PARITY_EN
    return stp && (($countones(d) + int'(p)) % 2 == 0);
`else
    return stp;
`endif
  endfunction

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stp,
                            input int low_hold, input int gap);
    int fall, t;
    drive_level(1'b0, N, fall);
    for (int i = 3; i >= 0; i--) drive_level(d[i], N, t);
`ifdef PH_PARITY_EN
    drive_level(p, N, t);
`endif
    drive_level(stp, N, t);
    if (frame_ok(d, p, stp)) begin
      exp_v.push_back('{cyc: fall + LAT, val: d});
      model_ph = d;
    end else begin
      exp_e.push_back(fall + LAT);
    end
    if (!stp) begin
      if (low_hold > 0) drive_level(1'b0, low_hold, t);
      drive_level(1'b1, (gap < 3) ? 3 : gap, t);
    end else if (gap > 0) begin
      drive_level(1'b1, gap, t);
    end
  endtask

  task automatic drain(input string tag);
    int nv, ne;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_count"}, got_v.size(), exp_v.size());
    check({tag, "_err_count"}, got_e.size(), exp_e.size());
    nv = (got_v.size() < exp_v.size()) ? got_v.size() : exp_v.size();
    ne = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
    for (int i = 0; i < nv; i++) begin
      check({tag, "_valid_cycle"}, got_v[i].cyc, exp_v[i].cyc);
      check({tag, "_valid_value"}, {28'b0, got_v[i].val}, {28'b0, exp_v[i].val});
    end
    for (int i = 0; i < ne; i++) check({tag, "_err_cycle"}, got_e[i], exp_e[i]);
    check({tag, "_bloodPH"}, {28'b0, bloodPH}, {28'b0, model_ph});
    exp_v.delete(); got_v.delete(); exp_e.delete(); got_e.delete();
  endtask

  initial begin
    int t;
    logic [3:0] d;
    logic p, stp;
    rst = 1'b1;
    sdi = 1'b1;
    model_ph = 4'b0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_bloodPH", {28'b0, bloodPH}, 32'd0);
    check("reset_phValid", {31'b0, phValid}, 32'd0);
    check("reset_frameErr", {31'b0, frameErr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_level(1'b1, 5, t);

    // Good frame 0111, even parity bit 1.
    send_frame(4'b0111, 1'b1, 1'b1, 0, 5);
    drain("good_0111");

    // 1001 with parity 1 (wrong when parity is checked).
    send_frame(4'b1001, 1'b1, 1'b1, 0, 5);
    drain("bad_parity");

    // Missing stop bit, line held low 20 more cycles, then a good frame.
    send_frame(4'b1000, 1'b1, 1'b0, 20, 6);
    send_frame(4'b1111, 1'b0, 1'b1, 0, 5);
    drain("stop_low");

    // One-cycle glitch, then a good frame proves the FSM is back in IDLE.
    drive_level(1'b0, 1, t);
    drive_level(1'b1, 10, t);
    drain("glitch");
    send_frame(4'b0101, 1'b0, 1'b1, 0, 5);
    drain("after_glitch");

    // Back-to-back frames with no idle gap.
    send_frame(4'b0000, 1'b0, 1'b1, 0, 0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 5);
    repeat (40) @(posedge clk);
    if (got_v.size() == 2) check("b2b_spacing", got_v[1].cyc - got_v[0].cyc, FB * N);
    drain("back_to_back");

    // Reset in the middle of DATA of frame 1001.
    drive_level(1'b0, N, t);
    drive_level(1'b1, N, t);
    drive_level(1'b0, 2, t);
    @(posedge clk);
    #1 begin rst = 1'b1; sdi = 1'b1; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ph = 4'b0000;
    @(negedge clk);
    check("midreset_bloodPH", {28'b0, bloodPH}, 32'd0);
    drive_level(1'b1, 4, t);
    drain("midreset");
    send_frame(4'b1001, 1'b0, 1'b1, 0, 5);
    drain("after_reset");

    // Randomized frames against the reference model.
    for (int k = 0; k < 20; k++) begin
      d   = 4'($urandom_range(0, 15));
      p   = ^d;
      if ($urandom_range(0, 3) == 0) p = ~p;
      stp = ($urandom_range(0, 4) != 0);
      send_frame(d, p, stp, $urandom_range(0, 10), $urandom_range(0, 5));
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
